// File: rtl/matvec_engine_if.sv
// Avalon-MM read-only bus between matvec_engine (master) and its word memory (slave).
interface matvec_engine_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic [WORD_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address,
        output read,
        input  readdata,
        input  readdatavalid,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        output readdata,
        output readdatavalid,
        output waitrequest
    );
endinterface

// File: rtl/matvec_engine.sv
// Matrix-vector engine C[r] = sum_k A[r][k]*B[k]: fetches B then A rows over Avalon-MM, ROWS MAC lanes.
// Optional MATVEC_SIGNED_EN selects two's-complement operands and results (default unsigned).
module matvec_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    localparam int unsigned ACC_WIDTH = 2*DATA_WIDTH + $clog2(COLS),
    localparam int unsigned SEL_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    matvec_engine_if.master       mem,
    input  logic [SEL_W-1:0]      res_sel,
    output logic [ACC_WIDTH-1:0]  res_data
);

    localparam int unsigned WORD_W = COLS*DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(ROWS+1);
    localparam int unsigned K_W    = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CALC, S_DONE} state_t;

    state_t state, state_nxt;

    logic load_job, accept, word_rcv, last_word, mac_en, calc_last;
    logic                  outstanding;
    logic [CNT_W-1:0]      word_cnt;
    logic [K_W-1:0]        k_cnt;
    logic [WORD_W-1:0]     b_buf;
    logic [WORD_W-1:0]     a_buf [ROWS];
    logic [ACC_WIDTH-1:0]  acc   [ROWS];
    logic [DATA_WIDTH-1:0] b_el;
    logic [DATA_WIDTH-1:0] a_el  [ROWS];

    // One lane's product, extended to accumulator width.
    function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
`ifdef MATVEC_SIGNED_EN
        logic signed [ACC_WIDTH-1:0] ea, eb;
        ea = ACC_WIDTH'($signed(a));
        eb = ACC_WIDTH'($signed(b));
        return ACC_WIDTH'(ea * eb);
`else
        return ACC_WIDTH'(a) * ACC_WIDTH'(b);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start)     state_nxt = S_FILL;
            S_FILL:         if (last_word) state_nxt = S_CALC;
            S_CALC:         if (calc_last) state_nxt = S_DONE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Per-state control strobes; readdatavalid only counts while a read is outstanding.
    always_comb begin
        load_job  = 1'b0;
        accept    = 1'b0;
        word_rcv  = 1'b0;
        last_word = 1'b0;
        mac_en    = 1'b0;
        calc_last = 1'b0;
        case (state)
            S_IDLE, S_DONE: load_job = start;
            S_FILL: begin
                accept    = mem.read & ~mem.waitrequest;
                word_rcv  = outstanding & mem.readdatavalid;
                last_word = word_rcv & (word_cnt == CNT_W'(ROWS));
            end
            S_CALC: begin
                mac_en    = 1'b1;
                calc_last = (k_cnt == K_W'(COLS-1));
            end
            default: ;
        endcase
    end

    // Column k of every A row and element k of B for the current CALC step.
    always_comb begin
        b_el = '0;
        for (int r = 0; r < ROWS; r++) a_el[r] = '0;
        for (int k = 0; k < COLS; k++) begin
            if (k_cnt == K_W'(k)) begin
                b_el = b_buf[k*DATA_WIDTH +: DATA_WIDTH];
                for (int r = 0; r < ROWS; r++) a_el[r] = a_buf[r][k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mem.read    <= 1'b0;
            mem.address <= '0;
            outstanding <= 1'b0;
            word_cnt    <= '0;
            k_cnt       <= '0;
            b_buf       <= '0;
            for (int r = 0; r < ROWS; r++) begin
                a_buf[r] <= '0;
                acc[r]   <= '0;
            end
        end else begin
            busy <= (state_nxt == S_FILL) || (state_nxt == S_CALC);
            done <= (state_nxt == S_DONE);
            if (load_job) begin
                mem.read    <= 1'b1;
                mem.address <= base_addr;
                outstanding <= 1'b0;
                word_cnt    <= '0;
                k_cnt       <= '0;
                for (int r = 0; r < ROWS; r++) acc[r] <= '0;
            end else begin
                if (accept) begin
                    mem.read    <= 1'b0;
                    outstanding <= 1'b1;
                end
                // Word 0 is B, word 1+r is A row r; the next request follows each response.
                if (word_rcv) begin
                    outstanding <= 1'b0;
                    if (word_cnt == '0) b_buf <= mem.readdata;
                    for (int r = 0; r < ROWS; r++) begin
                        if (word_cnt == CNT_W'(r+1)) a_buf[r] <= mem.readdata;
                    end
                    if (!last_word) begin
                        mem.read    <= 1'b1;
                        mem.address <= mem.address + ADDR_WIDTH'(1);
                        word_cnt    <= word_cnt + CNT_W'(1);
                    end
                end
                if (mac_en) begin
                    k_cnt <= k_cnt + K_W'(1);
                    for (int r = 0; r < ROWS; r++) acc[r] <= acc[r] + mac_term(a_el[r], b_el);
                end
            end
        end
    end

    // Result readout; selects beyond ROWS read as zero.
    always_comb begin
        res_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (res_sel == SEL_W'(r)) res_data = acc[r];
        end
    end

endmodule
